// File: rtl/interp_upsampler_pkg.sv
// Shared types and width helpers for the linear-interpolating upsampler.
package interp_upsampler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Accumulator carries the sample in its upper bits plus one guard bit, so a full
    // segment of delta additions can never overflow.
    function automatic int acc_width(input int data_w, input int log2_steps);
        return data_w + log2_steps + 1;
    endfunction

    function automatic int delta_width(input int data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/interp_upsampler_sample_buf1.sv
// One-deep next-sample holding register; an empty buffer passes input straight through
// when the consumer is taking a sample in the same cycle.
module sample_buf1 #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i
);
    logic              full_q;
    logic [DATA_W-1:0] data_q;

    assign in_ready_o  = !full_q;
    assign out_valid_o = full_q || in_valid_i;
    assign out_data_o  = full_q ? data_q : in_data_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (full_q) begin
            if (out_ready_i) begin
                full_q <= 1'b0;
            end
        end else if (in_valid_i && !out_ready_i) begin
            full_q <= 1'b1;
            data_q <= in_data_i;
        end
    end

endmodule

// File: rtl/interp_upsampler.sv
// Linear-interpolating upsampler: ramps 2**LOG2_STEPS outputs from the previous input
// sample to the current one, holding the last target when the source runs dry.
module interp_upsampler
    import interp_upsampler_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int LOG2_STEPS = 5
) (
    input  logic              i_clock,
    input  logic              i_RESET,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_underrun,
    output state_t            o_dbg_state
);
    // Valid/ready: a sample transfers on a rising edge where i_valid && o_ready; the source
    // keeps i_data stable while i_valid is high and o_ready is low.
    localparam int ACC_W   = acc_width(DATA_W, LOG2_STEPS);
    localparam int DELTA_W = delta_width(DATA_W);
    localparam logic [LOG2_STEPS-1:0] LAST_STEP = '1;

    state_t                state_q;
    logic [DATA_W-1:0]     prev_q;
    logic [DATA_W-1:0]     cur_q;
    logic [DELTA_W-1:0]    delta_q;
    logic [ACC_W-1:0]      acc_q;
    logic [LOG2_STEPS-1:0] step_q;
    logic                  underrun_q;

    logic                  buf_in_ready;
    logic                  buf_out_valid;
    logic [DATA_W-1:0]     buf_out_data;
    logic                  buf_pop;
    logic                  seg_end;
    logic [DATA_W-1:0]     base_d;
    logic [DELTA_W-1:0]    delta_d;
    logic [ACC_W-1:0]      acc_load_d;
    logic [ACC_W-1:0]      acc_step_d;

    sample_buf1 #(.DATA_W(DATA_W)) u_buf (
        .clk_i       (i_clock),
        .rst_i       (i_RESET),
        .in_valid_i  (i_valid),
        .in_data_i   (i_data),
        .in_ready_o  (buf_in_ready),
        .out_valid_o (buf_out_valid),
        .out_data_o  (buf_out_data),
        .out_ready_i (buf_pop)
    );

    // A new segment always starts from an exact reload of its base, so rounding in the
    // accumulator never drifts across segments.
    always_comb begin
        seg_end    = (state_q == RUN) && (step_q == LAST_STEP);
        buf_pop    = buf_out_valid && ((state_q != RUN) || seg_end);
        base_d     = (state_q == PRIME) ? prev_q : cur_q;
        delta_d    = {buf_out_data[DATA_W-1], buf_out_data} - {base_d[DATA_W-1], base_d};
        acc_load_d = {base_d[DATA_W-1], base_d, {LOG2_STEPS{1'b0}}};
        acc_step_d = acc_q + {{LOG2_STEPS{delta_q[DELTA_W-1]}}, delta_q};
    end

    always_ff @(posedge i_clock or posedge i_RESET) begin
        if (i_RESET) begin
            state_q    <= IDLE;
            prev_q     <= '0;
            cur_q      <= '0;
            delta_q    <= '0;
            acc_q      <= '0;
            step_q     <= '0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (buf_pop) begin
                        prev_q  <= buf_out_data;
                        state_q <= PRIME;
                    end
                end
                PRIME, HOLD: begin
                    if (buf_pop) begin
                        prev_q  <= base_d;
                        cur_q   <= buf_out_data;
                        delta_q <= delta_d;
                        acc_q   <= acc_load_d;
                        step_q  <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q  <= acc_step_d;
                    step_q <= step_q + 1'b1;
                    if (seg_end) begin
                        if (buf_pop) begin
                            prev_q  <= base_d;
                            cur_q   <= buf_out_data;
                            delta_q <= delta_d;
                            acc_q   <= acc_load_d;
                            step_q  <= '0;
                        end else begin
                            state_q    <= HOLD;
                            underrun_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output slice of the accumulator is a floor division by the step count.
    assign o_ready     = buf_in_ready && !i_RESET;
    assign o_valid     = (state_q == RUN) || (state_q == HOLD);
    assign o_data      = (state_q == RUN)  ? acc_q[LOG2_STEPS +: DATA_W] :
                         (state_q == HOLD) ? cur_q : '0;
    assign o_underrun  = underrun_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_interp_upsampler.sv
// Self-checking bench for interp_upsampler (DATA_W=32, LOG2_STEPS=2): directed scenarios
// plus randomized traffic against a segment-level reference model.
module tb_interp_upsampler;
    import interp_upsampler_pkg::*;

    localparam int DATA_W     = 32;
    localparam int LOG2_STEPS = 2;
    localparam int N          = 1 << LOG2_STEPS;

    logic              i_clock = 1'b0;
    logic              i_RESET = 1'b1;
    logic [DATA_W-1:0] i_data  = '0;
    logic              i_valid = 1'b0;
    logic              o_ready;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              o_underrun;
    state_t            o_dbg_state;

    int n_checks  = 0;
    int n_fail    = 0;
    int stall_cnt = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] obs_q[$];
    int                und_q[$];
    bit                rec_en = 1'b0;

    interp_upsampler #(.DATA_W(DATA_W), .LOG2_STEPS(LOG2_STEPS)) dut (
        .i_clock     (i_clock),
        .i_RESET     (i_RESET),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_underrun  (o_underrun),
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 i_clock = ~i_clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        i_valid = 1'b0;
        i_RESET = 1'b1;
        @(posedge i_clock);
        @(posedge i_clock);
        #1 i_RESET = 1'b0;
    endtask

    // Records every valid output sample and where underrun pulses fall in that stream.
    always @(negedge i_clock) begin
        if (rec_en && !i_RESET) begin
            if (o_underrun) und_q.push_back(obs_q.size());
            if (o_valid) obs_q.push_back(o_data);
        end
    end

    function automatic longint sx(input logic [DATA_W-1:0] v);
        return longint'($signed(v));
    endfunction

    // floor(a + k*(b-a)/N) with exact integer arithmetic
    function automatic longint interp(input longint a, input longint b, input int k);
        longint num;
        longint q;
        num = a * N + longint'(k) * (b - a);
        q = num / N;
        if ((num % N) != 0 && num < 0) q = q - 1;
        return q;
    endfunction

    // ---------------- driver ----------------
    task automatic send(input logic [DATA_W-1:0] v);
        bit acc;
        acc = 1'b0;
        i_valid = 1'b1;
        i_data  = v;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge i_clock);
            acc = o_ready;
            if (!o_ready) stall_cnt++;
            @(posedge i_clock);
            #1;
        end
        i_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: sample %0d not accepted, required acceptance within 200 cycles", $signed(v));
        end
    endtask

    task automatic start_rec();
        obs_q.delete();
        und_q.delete();
        exp_q.delete();
        rec_en = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_RESET = 1'b1;
        #2;
        n_checks++;
        if ({o_valid, o_ready, o_underrun} !== 3'b000 || o_data !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid/ready/underrun=%b data=%0h, required 000 data=0",
                     {o_valid, o_ready, o_underrun}, o_data);
        end
        do_reset();
        @(negedge i_clock);
        n_checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b valid=%b state=%0d, required ready=1 valid=0 IDLE",
                     o_ready, o_valid, o_dbg_state);
        end
        @(posedge i_clock);
        #1;
    endtask

    task automatic test_ramp();
        do_reset();
        start_rec();
        send(32'd0);
        send(32'd8);
        send(32'd16);
        repeat (12) @(posedge i_clock);
        #1 rec_en = 1'b0;
        for (int k = 0; k < 8; k++) exp_q.push_back(DATA_W'(2 * k));
        exp_q.push_back(32'd16);
        exp_q.push_back(32'd16);
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL ramp_data[%0d]: got %0d, required %0d", i,
                         (i < obs_q.size()) ? $signed(obs_q[i]) : -999, $signed(exp_q[i]));
            end
        end
        n_checks++;
        if (und_q.size() != 1 || und_q[0] != 8) begin
            n_fail++;
            $display("FAIL ramp_underrun: %0d pulses first at %0d, required 1 pulse at output 8",
                     und_q.size(), (und_q.size() > 0) ? und_q[0] : -1);
        end
    endtask

    task automatic test_negative();
        do_reset();
        start_rec();
        send(32'd0);
        send(-32'sd3);
        repeat (8) @(posedge i_clock);
        #1 rec_en = 1'b0;
        exp_q = '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFD};
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL neg_data[%0d]: got %0d, required %0d", i,
                         (i < obs_q.size()) ? $signed(obs_q[i]) : -999, $signed(exp_q[i]));
            end
        end
        n_checks++;
        if (und_q.size() != 1 || und_q[0] != 4) begin
            n_fail++;
            $display("FAIL neg_underrun: %0d pulses first at %0d, required 1 pulse at output 4",
                     und_q.size(), (und_q.size() > 0) ? und_q[0] : -1);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        start_rec();
        stall_cnt = 0;
        send(32'd100);
        send(32'd200);
        send(32'd300);
        send(32'd400);
        repeat (16) @(posedge i_clock);
        #1 rec_en = 1'b0;
        for (int s = 0; s < 3; s++)
            for (int k = 0; k < N; k++) exp_q.push_back(DATA_W'(100 + 100 * s + 25 * k));
        exp_q.push_back(32'd400);
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL b2b_data[%0d]: got %0d, required %0d", i,
                         (i < obs_q.size()) ? $signed(obs_q[i]) : -999, $signed(exp_q[i]));
            end
        end
        n_checks++;
        if (und_q.size() != 1 || und_q[0] != 12) begin
            n_fail++;
            $display("FAIL b2b_underrun: %0d pulses first at %0d, required 1 pulse at output 12",
                     und_q.size(), (und_q.size() > 0) ? und_q[0] : -1);
        end
        n_checks++;
        if (stall_cnt == 0) begin
            n_fail++;
            $display("FAIL b2b_backpressure: stall cycles %0d, required >0", stall_cnt);
        end
    endtask

    task automatic test_hold_restart();
        do_reset();
        send(32'd0);
        send(32'd8);
        send(32'd16);
        repeat (22) @(posedge i_clock);
        @(negedge i_clock);
        n_checks++;
        if (o_valid !== 1'b1 || o_data !== 32'd16 || o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_value: valid=%b ready=%b data=%0d, required valid=1 ready=1 data=16",
                     o_valid, o_ready, $signed(o_data));
        end
        @(posedge i_clock);
        #1;
        send(32'd0);
        start_rec();
        repeat (6) @(posedge i_clock);
        #1 rec_en = 1'b0;
        exp_q = '{32'd16, 32'd12, 32'd8, 32'd4, 32'd0, 32'd0};
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL restart_data[%0d]: got %0d, required %0d", i,
                         (i < obs_q.size()) ? $signed(obs_q[i]) : -999, $signed(exp_q[i]));
            end
        end
        n_checks++;
        if (und_q.size() != 1 || und_q[0] != 4) begin
            n_fail++;
            $display("FAIL restart_underrun: %0d pulses first at %0d, required 1 pulse at output 4",
                     und_q.size(), (und_q.size() > 0) ? und_q[0] : -1);
        end
    endtask

    task automatic test_extremes();
        longint v;
        do_reset();
        start_rec();
        send(32'h7FFF_FFFF);
        send(32'h8000_0000);
        repeat (6) @(posedge i_clock);
        #1 rec_en = 1'b0;
        for (int k = 0; k < N; k++) begin
            v = interp(64'sd2147483647, -64'sd2147483648, k);
            exp_q.push_back(DATA_W'(v));
        end
        exp_q.push_back(32'h8000_0000);
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL extreme_data[%0d]: got %0h, required %0h", i,
                         (i < obs_q.size()) ? obs_q[i] : 32'h0, exp_q[i]);
            end
        end
        for (int i = 0; i + 1 < 5 && i + 1 < obs_q.size(); i++) begin
            n_checks++;
            if (sx(obs_q[i + 1]) >= sx(obs_q[i])) begin
                n_fail++;
                $display("FAIL extreme_monotonic[%0d]: %0d then %0d, required strictly decreasing",
                         i, $signed(obs_q[i]), $signed(obs_q[i + 1]));
            end
        end
    endtask

    task automatic test_reset_mid();
        bit saw_valid;
        do_reset();
        send(32'd10);
        send(32'd50);
        @(posedge i_clock);
        #1 i_RESET = 1'b1;
        #1;
        n_checks++;
        if (o_valid !== 1'b0 || o_data !== '0 || o_ready !== 1'b0 || o_underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_async: valid=%b ready=%b und=%b data=%0d, required all 0",
                     o_valid, o_ready, o_underrun, $signed(o_data));
        end
        @(posedge i_clock);
        #1 i_RESET = 1'b0;
        send(32'd7);
        saw_valid = 1'b0;
        repeat (3) begin
            @(negedge i_clock);
            if (o_valid || o_underrun) saw_valid = 1'b1;
        end
        n_checks++;
        if (saw_valid) begin
            n_fail++;
            $display("FAIL midreset_one_sample: output seen after one sample, required none");
        end
        @(posedge i_clock);
        #1;
        send(32'd11);
        @(negedge i_clock);
        n_checks++;
        if (o_valid !== 1'b1 || o_data !== 32'd7) begin
            n_fail++;
            $display("FAIL midreset_restart: valid=%b data=%0d, required valid=1 data=7",
                     o_valid, $signed(o_data));
        end
        @(posedge i_clock);
        #1;
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] pend_q[$];
        logic [DATA_W-1:0] smp;
        logic [DATA_W-1:0] e_data;
        longint a, b;
        int     k, md;
        bit     have, acc, und_exp, und_next, e_valid, e_ready;
        a = 0; b = 0; k = 0; md = 0; have = 0; und_exp = 0; smp = '0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (!have && $urandom_range(0, ((c / 150) % 2 == 0) ? 1 : 7) == 0) begin
                have = 1'b1;
                if ($urandom_range(0, 7) == 0) smp = $urandom;
                else smp = DATA_W'($urandom_range(0, 2000)) - 32'd1000;
            end
            i_valid = have;
            i_data  = smp;
            @(negedge i_clock);
            e_valid = (md >= 2);
            e_ready = (md != 2) || (pend_q.size() == 0);
            e_data  = (md == 2) ? DATA_W'(interp(a, b, k)) : (md == 3) ? DATA_W'(b) : '0;
            n_checks++;
            if (o_valid !== e_valid || o_ready !== e_ready || o_underrun !== und_exp) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d]: valid/ready/und=%b%b%b, required %b%b%b",
                         c, o_valid, o_ready, o_underrun, e_valid, e_ready, und_exp);
            end
            if (e_valid) begin
                n_checks++;
                if (o_data !== e_data) begin
                    n_fail++;
                    $display("FAIL rand_data[%0d]: got %0d, required %0d", c, $signed(o_data), $signed(e_data));
                end
            end
            acc = have && e_ready;
            und_next = 1'b0;
            case (md)
                0: if (acc) begin a = sx(smp); md = 1; end
                1: if (acc) begin b = sx(smp); k = 0; md = 2; end
                2: begin
                    if (acc) pend_q.push_back(smp);
                    if (k == N - 1) begin
                        if (pend_q.size() > 0) begin
                            a = b;
                            b = sx(pend_q.pop_front());
                            k = 0;
                        end else begin
                            md = 3;
                            und_next = 1'b1;
                        end
                    end else begin
                        k++;
                    end
                end
                default: if (acc) begin a = b; b = sx(smp); k = 0; md = 2; end
            endcase
            und_exp = und_next;
            @(posedge i_clock);
            #1;
            if (acc) have = 1'b0;
        end
        i_valid = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_ramp();
        test_negative();
        test_back_to_back();
        test_hold_restart();
        test_extremes();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
